// File: rtl/ad_ip_jesd204_tpl_dac_sel_ctrl_if.sv
// Register-map side and datapath side signals of the DAC data-source selection controller.
// Handshake: cfg_update, ext_sync and link_ready are qualifiers sampled on the link_clk edge; dac_sync is a one-cycle strobe.
interface ad_ip_jesd204_tpl_dac_sel_ctrl_if #(
  parameter int NUM_CHANNELS = 2
);
  logic [NUM_CHANNELS*4-1:0] cfg_data_sel;
  logic                      cfg_update;
  logic                      cfg_sync_mode;
  logic                      ext_sync;
  logic                      link_ready;
  logic                      dac_dunf;
  logic                      unf_mute_en;
  logic [NUM_CHANNELS*4-1:0] dac_data_sel;
  logic                      dac_sync;
  logic                      busy;
  logic                      timeout;
  logic                      unf_muted;

  modport master (
    output cfg_data_sel, cfg_update, cfg_sync_mode, ext_sync, link_ready, dac_dunf, unf_mute_en,
    input  dac_data_sel, dac_sync, busy, timeout, unf_muted
  );

  modport slave (
    input  cfg_data_sel, cfg_update, cfg_sync_mode, ext_sync, link_ready, dac_dunf, unf_mute_en,
    output dac_data_sel, dac_sync, busy, timeout, unf_muted
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_sel_ctrl.sv
// Sequences atomic per-channel data-source changes onto link_ready beats with a dac_sync pulse,
// and masks DMA-sourced channels to zero while a DMA underflow holdoff is running.
module ad_ip_jesd204_tpl_dac_sel_ctrl #(
  parameter int NUM_CHANNELS = 2,
  parameter int ARM_TIMEOUT  = 65535,
  parameter int UNF_HOLDOFF  = 16
) (
  input  logic                          link_clk,
  input  logic                          rst,
  ad_ip_jesd204_tpl_dac_sel_ctrl_if.slave sel_if,
  output logic [1:0]                    dbg_state
);

  localparam int SW = NUM_CHANNELS * 4;
  localparam int TW = (ARM_TIMEOUT > 0) ? $clog2(ARM_TIMEOUT + 1) : 1;
  localparam int HW = (UNF_HOLDOFF > 1) ? $clog2(UNF_HOLDOFF + 1) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(ARM_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(UNF_HOLDOFF);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SYNC  = 2'd1,
    WAIT_READY = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   pending;
  logic [SW-1:0]   applied;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hold;
  logic            sync_r;
  logic            busy_r;
  logic            timeout_r;
  logic            muted_r;
  logic [SW-1:0]   sel_eff;

  always_ff @(posedge link_clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      applied   <= '0;
      tcnt      <= '0;
      sync_r    <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      sync_r <= 1'b0;
      // A new request restarts the sequence from any state and beats ext_sync/link_ready.
      if (sel_if.cfg_update) begin
        pending   <= sel_if.cfg_data_sel;
        timeout_r <= 1'b0;
        tcnt      <= '0;
        busy_r    <= 1'b1;
        state     <= sel_if.cfg_sync_mode ? WAIT_SYNC : WAIT_READY;
      end else begin
        case (state)
          WAIT_SYNC: begin
            if (sel_if.ext_sync) begin
              state <= WAIT_READY;
            end else if ((ARM_TIMEOUT != 0) && (tcnt == TCNT_LAST)) begin
              state     <= IDLE;
              busy_r    <= 1'b0;
              timeout_r <= 1'b1;
              pending   <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          WAIT_READY: begin
            if (sel_if.link_ready) begin
              applied <= pending;
              sync_r  <= 1'b1;
              busy_r  <= 1'b0;
              state   <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Holdoff counts clean cycles; the mute drops on the edge where it would hit zero.
  always_ff @(posedge link_clk) begin
    if (rst || !sel_if.unf_mute_en) begin
      muted_r <= 1'b0;
      hold    <= '0;
    end else if (sel_if.dac_dunf) begin
      muted_r <= 1'b1;
      hold    <= HOLD_LOAD;
    end else if (muted_r) begin
      if (hold <= HW'(1)) begin
        muted_r <= 1'b0;
        hold    <= '0;
      end else begin
        hold <= hold - 1'b1;
      end
    end
  end

  always_comb begin
    sel_eff = applied;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (muted_r && (applied[i*4 +: 4] == 4'd2)) begin
        sel_eff[i*4 +: 4] = 4'd3;
      end
    end
  end

  assign sel_if.dac_data_sel = sel_eff;
  assign sel_if.dac_sync     = sync_r;
  assign sel_if.busy         = busy_r;
  assign sel_if.timeout      = timeout_r;
  assign sel_if.unf_muted    = muted_r;
  assign dbg_state           = state;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sel_ctrl.sv
// Scoreboard bench for the DAC selection controller: directed scenarios then random traffic.
module tb_ad_ip_jesd204_tpl_dac_sel_ctrl;
  localparam int NCH  = 2;
  localparam int ARM  = 8;
  localparam int HOLD = 4;
  localparam int SW   = NCH * 4;
  localparam int EW   = SW + 4;

  // clock / reset
  logic link_clk = 1'b0;
  logic rst;
  always #5 link_clk = ~link_clk;

  ad_ip_jesd204_tpl_dac_sel_ctrl_if #(.NUM_CHANNELS(NCH)) sif ();
  logic [1:0] dbg_state;

  ad_ip_jesd204_tpl_dac_sel_ctrl #(
    .NUM_CHANNELS(NCH),
    .ARM_TIMEOUT (ARM),
    .UNF_HOLDOFF (HOLD)
  ) dut (
    .link_clk (link_clk),
    .rst      (rst),
    .sel_if   (sif),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] apply_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model: phase 0 idle, 1 waiting for trigger, 2 waiting for ready
  int            phase     = 0;
  int            arm_cyc   = 0;
  int            unmute_at = 0;
  logic [SW-1:0] m_pending = '0;
  logic [SW-1:0] m_applied = '0;
  logic          m_timeout = 1'b0;

  function automatic logic [SW-1:0] masked(input logic [SW-1:0] a, input logic mu);
    logic [SW-1:0] r;
    r = a;
    for (int i = 0; i < NCH; i++)
      if (mu && a[i*4 +: 4] == 4'd2) r[i*4 +: 4] = 4'd3;
    return r;
  endfunction

  // Advance the model over the coming edge, clock it, then queue what should be visible.
  task automatic tick();
    logic          sync_n;
    logic          mu_n;
    logic [EW-1:0] e;
    int            t;
    t      = cyc;
    sync_n = 1'b0;
    if (rst) begin
      phase     = 0;
      m_pending = '0;
      m_applied = '0;
      m_timeout = 1'b0;
      unmute_at = 0;
    end else begin
      if (sif.cfg_update) begin
        m_pending = sif.cfg_data_sel;
        m_timeout = 1'b0;
        arm_cyc   = t;
        phase     = sif.cfg_sync_mode ? 1 : 2;
      end else if (phase == 1) begin
        if (sif.ext_sync) phase = 2;
        else if (t - arm_cyc == ARM) begin
          phase     = 0;
          m_timeout = 1'b1;
        end
      end else if (phase == 2 && sif.link_ready) begin
        m_applied = m_pending;
        sync_n    = 1'b1;
        phase     = 0;
      end
      if (!sif.unf_mute_en) unmute_at = 0;
      else if (sif.dac_dunf) unmute_at = t + 1 + HOLD;
    end
    mu_n = (t + 1) < unmute_at;
    e = {masked(m_applied, mu_n), sync_n, (phase != 0), m_timeout, mu_n};
    if (sync_n) apply_q.push_back(masked(m_applied, mu_n));
    @(posedge link_clk);
    exp_q.push_back(e);
    cyc++;
    #1;
  endtask

  // driver tasks
  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic update(input logic [SW-1:0] sel, input logic mode);
    sif.cfg_data_sel  = sel;
    sif.cfg_sync_mode = mode;
    sif.cfg_update    = 1'b1;
    tick();
    sif.cfg_update    = 1'b0;
  endtask

  task automatic pulse_sync();
    sif.ext_sync = 1'b1;
    tick();
    sif.ext_sync = 1'b0;
  endtask

  task automatic pulse_dunf();
    sif.dac_dunf = 1'b1;
    tick();
    sif.dac_dunf = 1'b0;
  endtask

  // monitor
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_act;
  logic [SW-1:0] mon_apply;
  always @(negedge link_clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {sif.dac_data_sel, sif.dac_sync, sif.busy, sif.timeout, sif.unf_muted};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL outputs cyc=%0d got sel=%h sync=%b busy=%b timeout=%b muted=%b want sel=%h sync=%b busy=%b timeout=%b muted=%b",
                 cyc, mon_act[EW-1:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                 mon_exp[EW-1:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
    if (sif.dac_sync === 1'b1) begin
      checks++;
      if (apply_q.size() == 0) begin
        failures++;
        $display("FAIL apply cyc=%0d got dac_sync with sel=%h want no apply", cyc, sif.dac_data_sel);
      end else begin
        mon_apply = apply_q.pop_front();
        if (sif.dac_data_sel !== mon_apply) begin
          failures++;
          $display("FAIL apply cyc=%0d got sel=%h want %h", cyc, sif.dac_data_sel, mon_apply);
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    sif.cfg_data_sel  = '0;
    sif.cfg_update    = 1'b0;
    sif.cfg_sync_mode = 1'b0;
    sif.ext_sync      = 1'b0;
    sif.link_ready    = 1'b1;
    sif.dac_dunf      = 1'b0;
    sif.unf_mute_en   = 1'b0;
    run(3);
    rst = 1'b0;
    run(2);

    // immediate apply
    update(8'h22, 1'b0);
    run(3);

    // triggered apply with ready toggling after the trigger
    sif.link_ready = 1'b0;
    update(8'h11, 1'b1);
    run(5);
    pulse_sync();
    for (int i = 0; i < 6; i++) begin
      sif.link_ready = (i % 3 == 2);
      tick();
    end
    sif.link_ready = 1'b1;
    run(2);

    // arm timeout, then a fresh request clears it
    update(8'h23, 1'b1);
    run(11);
    pulse_sync();
    update(8'h20, 1'b0);
    run(3);

    // restart overrides a pending triggered request
    update(8'h33, 1'b1);
    run(2);
    update(8'h20, 1'b0);
    run(3);

    // underflow mute, extension, and disable
    sif.unf_mute_en = 1'b1;
    pulse_dunf();
    run(2);
    pulse_dunf();
    run(6);
    pulse_dunf();
    run(1);
    sif.unf_mute_en = 1'b0;
    run(3);

    // reset while stalled waiting for ready
    sif.link_ready = 1'b0;
    update(8'h12, 1'b0);
    run(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sif.link_ready = 1'b1;
    run(3);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      sif.cfg_update    = ($urandom_range(0, 11) == 0);
      for (int c = 0; c < NCH; c++)
        sif.cfg_data_sel[c*4 +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                                   : 4'($urandom_range(0, 3));
      sif.cfg_sync_mode = 1'($urandom_range(0, 1));
      sif.ext_sync      = ($urandom_range(0, 9) == 0);
      sif.link_ready    = 1'($urandom_range(0, 1));
      sif.dac_dunf      = ($urandom_range(0, 24) == 0);
      sif.unf_mute_en   = ($urandom_range(0, 29) != 0);
      rst               = ($urandom_range(0, 199) == 0);
      tick();
    end

    // drain
    rst               = 1'b0;
    sif.cfg_update    = 1'b0;
    sif.ext_sync      = 1'b0;
    sif.dac_dunf      = 1'b0;
    sif.link_ready    = 1'b1;
    run(4);
    #10;
    checks++;
    if (apply_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d outstanding applies want 0", apply_q.size());
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ad_ip_jesd204_tpl_dac_sel_ctrl.md
# ad_ip_jesd204_tpl_dac_sel_ctrl

Link-clock-domain controller that sequences per-channel data-source changes for the JESD204 transport-layer DAC datapath. Captures a requested selection vector on a software update strobe, optionally arms and waits for an external sync trigger, and applies all channels atomically on a `link_ready` beat while pulsing `dac_sync` to realign the DDS phase accumulators. Also masks DMA-sourced channels to zero output on DMA underflow until the stream has been clean for a programmable holdoff. Sits between the register map (already in `link_clk` domain) and the datapath core's `dac_data_sel`/`dac_sync` inputs.

## Interface
Clock/reset: one clock (`link_clk`); reset `rst` is synchronous, active-high.

**Parameters**
- `NUM_CHANNELS`, 2, number of converter channels.
- `ARM_TIMEOUT`, 65535, cycles allowed in WAIT_SYNC before abort; 0 disables timeout.
- `UNF_HOLDOFF`, 16, consecutive underflow-free cycles required before unmuting; minimum 1.

**Ports**
- `link_clk`  in  1  datapath clock.
- `rst`  in  1  synchronous active-high reset.
- `cfg_data_sel`  in  NUM_CHANNELS*4  requested selection, 4 bits per channel, channel 0 in LSBs.
- `cfg_update`  in  1  single-cycle request to capture and apply `cfg_data_sel`.
- `cfg_sync_mode`  in  1  sampled with `cfg_update`; 0 = apply on next ready beat, 1 = wait for `ext_sync`.
- `ext_sync`  in  1  single-cycle external trigger.
- `link_ready`  in  1  link accepting data; apply only when high.
- `dac_dunf`  in  1  DMA underflow indication.
- `unf_mute_en`  in  1  enables underflow muting.
- `dac_data_sel`  out  NUM_CHANNELS*4  effective selection to the core.
- `dac_sync`  out  1  one-cycle pulse on apply.
- `busy`  out  1  high in WAIT_SYNC or WAIT_READY.
- `timeout`  out  1  sticky; arm aborted by timeout.
- `unf_muted`  out  1  muting active.

## Operation
- **Selection codes:** 0 = DDS, 1 = pattern, 2 = DMA, 3 = zero; other codes pass through unchanged.
- **Registers:**
  - `pending` (captured selection).
  - `applied` (active selection).
  - `state`.
  - timeout counter, width clog2(ARM_TIMEOUT+1).
  - holdoff counter, width clog2(UNF_HOLDOFF+1).
- **FSM**
  - **IDLE:**
    - On `cfg_update`: `pending` <= `cfg_data_sel`, `timeout` <= 0, timeout counter <= 0.
    - Next state is WAIT_SYNC if `cfg_sync_mode`=1, else WAIT_READY.
    - `ext_sync` is ignored in IDLE.
  - **WAIT_SYNC:**
    - On `ext_sync`, go to WAIT_READY.
    - Otherwise the counter increments each cycle. When ARM_TIMEOUT≠0 and the counter reaches ARM_TIMEOUT-1 without `ext_sync`: go to IDLE, set `timeout`=1, discard `pending`.
    - If `ext_sync` arrives in the same cycle as expiry, `ext_sync` wins.
  - **WAIT_READY:** when `link_ready`=1: `applied` <= `pending`, `dac_sync` <= 1 for one cycle, go to IDLE.
  - **`cfg_update` in WAIT_SYNC/WAIT_READY:** restarts the sequence. Recapture `pending`, resample `cfg_sync_mode`, clear the counter and `timeout`, then go to WAIT_SYNC/WAIT_READY per the new mode. `cfg_update` has priority over `ext_sync` and `link_ready` in that cycle; no apply occurs.
- **Underflow mute**
  - When `unf_mute_en`=1 and `dac_dunf`=1: `unf_muted` <= 1 and holdoff <= UNF_HOLDOFF.
  - While muted with `dac_dunf`=0, holdoff decrements. On the cycle holdoff would reach 0, `unf_muted` <= 0.
  - `dac_dunf` during holdoff reloads the counter.
  - `unf_mute_en`=0 clears `unf_muted` and holdoff on the next edge.
- **Effective selection (combinational from registers):** per channel, `dac_data_sel` = 3 if `unf_muted` and `applied`==2; otherwise `applied`. Muting never alters `applied` or `pending`.
- **Reset values:**
  - `applied` = all 0 (DDS), so `dac_data_sel` = 0.
  - `dac_sync`, `busy`, `timeout`, `unf_muted` = 0; state IDLE.
- **Reset mid-sequence:** abandons `pending` with no `dac_sync` pulse.

## Timing
- Immediate mode: `cfg_update` at cycle N, `link_ready`=1 at N+1 → new `dac_data_sel` and `dac_sync`=1 visible at N+2. Minimum latency is 2 cycles.
- `link_ready` low stalls the apply indefinitely with `busy`=1; no timeout applies in WAIT_READY.
- Sync mode: `ext_sync` at cycle M in WAIT_SYNC, `link_ready` high → apply visible at M+2.
- `busy` is high from N+1 through the apply cycle and low the cycle `dac_sync` is high.
- `dac_sync` is exactly one cycle wide and never asserted back-to-back.
- `dac_dunf` at cycle K → `unf_muted` and masked selection visible at K+1. After the last `dac_dunf` at cycle L, `unf_muted` deasserts at L+1+UNF_HOLDOFF.

## Test plan
- **Reset defaults:** after reset, `dac_data_sel`=0, all status outputs 0. `cfg_update` with `cfg_data_sel`=0x22, mode 0, `link_ready`=1 → `dac_data_sel`=0x22 and `dac_sync` pulse exactly 2 cycles later.
- **Sync-mode apply:** mode 1, `cfg_data_sel`=0x11, `ext_sync` after 100 cycles, `link_ready` toggling → apply on the first ready beat after `ext_sync`; `busy` high throughout.
- **Timeout:** ARM_TIMEOUT=8, mode 1, no `ext_sync` → after 8 cycles in WAIT_SYNC, `timeout`=1, `busy`=0, `dac_data_sel` unchanged. A subsequent `cfg_update` clears `timeout`.
- **Restart:** `cfg_update`(0x33, mode 1), then 3 cycles later `cfg_update`(0x20, mode 0) → single apply of 0x20, one `dac_sync` pulse, 0x33 never appears.
- **Underflow mute:** `applied`=0x20, `unf_mute_en`=1, UNF_HOLDOFF=4, `dac_dunf` pulse → `dac_data_sel`=0x30 the next cycle, back to 0x20 after 4 clean cycles. A second `dac_dunf` during holdoff extends the mute; clearing `unf_mute_en` unmutes on the next edge.
- **Reset during WAIT_READY:** with `link_ready`=0 → no `dac_sync`, `dac_data_sel`=0 after reset.
